// File: rtl/ioctl_load_sequencer.sv
// Bridges the hps_io ioctl stream to the core ROM port through a small FIFO, latches mod/DIP bytes
// and sequences core_reset. Define IOCTL_LOAD_SEQUENCER_CHECKSUM_EN to build the rom_sum adder.
module ioctl_load_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int RST_HOLD   = 64
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [15:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        rom_wr,
    input  logic        rom_ready,
    output logic [7:0]  mod,
    output logic [63:0] sw,
    output logic        core_reset,
    output logic        overflow,
    output logic [7:0]  rom_sum
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(RST_HOLD + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_HOLD} state_t;

    state_t        state_q;
    logic [HW-1:0] hold_cnt_q;
    logic          core_reset_q;

    logic [23:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    mod_q, mod_d;
    logic [63:0]   sw_q, sw_d;

    logic rom_start, load_entry, rom_accept, rom_push, rom_pop, fifo_full;

    assign rom_start  = ioctl_download & (ioctl_index == 8'd0);
    assign load_entry = (state_q == S_IDLE) & rom_start;
    assign rom_accept = ioctl_wr & rom_start & (ioctl_addr[24:16] == 9'd0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign rom_wr     = (count_q != '0);
    assign rom_pop    = rom_wr & rom_ready;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign rom_push   = rom_accept & (~fifo_full | rom_pop);

    // Head entry is read first-word-fall-through; its slot is not rewritten until it pops.
    assign rom_addr   = mem_q[rd_ptr_q][23:8];
    assign rom_data   = mem_q[rd_ptr_q][7:0];
    // Raised one entry early so a strobe already in flight from the HPS still fits.
    assign ioctl_wait = (count_q >= CW'(FIFO_DEPTH - 1));

    assign core_reset = core_reset_q;
    assign overflow   = overflow_q;
    assign mod        = mod_q;
    assign sw         = sw_q;

    always_comb begin
        wr_ptr_d   = rom_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = rom_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        overflow_d = overflow_q | (rom_accept & fifo_full & ~rom_pop);
        count_d    = count_q;
        case ({rom_push, rom_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        mod_d = mod_q;
        sw_d  = sw_q;
        if (ioctl_wr && ioctl_index == 8'd1)
            mod_d = ioctl_dout;
        if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr[24:3] == 22'd0)
            sw_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
    end

    always_ff @(posedge clk_sys) begin
        if (rom_push)
            mem_q[wr_ptr_q] <= {ioctl_addr[15:0], ioctl_dout};
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            mod_q      <= 8'd0;
            sw_q       <= 64'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            mod_q      <= mod_d;
            sw_q       <= sw_d;
        end
    end

    // core_reset is registered alongside the state, so it is high in every non-IDLE state.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= S_HOLD;
            hold_cnt_q   <= HW'(RST_HOLD);
            core_reset_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_entry) begin
                        state_q      <= S_LOAD;
                        core_reset_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (!ioctl_download)
                        state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (rom_start) begin
                        state_q <= S_LOAD;
                    end else if (!rom_wr) begin
                        state_q    <= S_HOLD;
                        hold_cnt_q <= HW'(RST_HOLD);
                    end
                end
                S_HOLD: begin
                    if (rom_start) begin
                        state_q <= S_LOAD;
                    end else if (hold_cnt_q == HW'(1)) begin
                        state_q      <= S_IDLE;
                        core_reset_q <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - HW'(1);
                    end
                end
                default: begin
                    state_q      <= S_HOLD;
                    hold_cnt_q   <= HW'(RST_HOLD);
                    core_reset_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef IOCTL_LOAD_SEQUENCER_CHECKSUM_EN
    logic [7:0] rom_sum_q, rom_sum_d;

    always_comb begin
        rom_sum_d = rom_sum_q;
        if (load_entry)
            rom_sum_d = 8'd0;
        else if (rom_pop)
            rom_sum_d = rom_sum_q + rom_data;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            rom_sum_q <= 8'd0;
        else
            rom_sum_q <= rom_sum_d;
    end

    assign rom_sum = rom_sum_q;
`else
    assign rom_sum = 8'd0;
`endif

endmodule

// File: tb/tb_ioctl_load_sequencer.sv
// Bench for ioctl_load_sequencer: directed scenarios plus random traffic, all checked each cycle
// against a queue-based reference model of the download rules.
module tb_ioctl_load_sequencer;
    localparam int DEPTH = 4;
    localparam int HOLD  = 64;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic        rom_ready = 1'b1;
    logic        ioctl_wait;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_wr;
    logic [7:0]  mod;
    logic [63:0] sw;
    logic        core_reset;
    logic        overflow;
    logic [7:0]  rom_sum;

    ioctl_load_sequencer #(.FIFO_DEPTH(DEPTH), .RST_HOLD(HOLD)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait),
        .rom_addr(rom_addr), .rom_data(rom_data), .rom_wr(rom_wr), .rom_ready(rom_ready),
        .mod(mod), .sw(sw), .core_reset(core_reset), .overflow(overflow), .rom_sum(rom_sum)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: FIFO as a queue, load/drain/hold as flags plus a remaining-cycles count.
    logic [23:0] mq[$];
    bit          m_ovf;
    logic [7:0]  m_mod;
    logic [63:0] m_sw;
    logic [7:0]  m_sum;
    bit          m_loading, m_draining;
    int          m_hold_left;

    logic [23:0] popped[$];
    bit          wait_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_sum();
`ifdef IOCTL_LOAD_SEQUENCER_CHECKSUM_EN
        return m_sum;
`else
        return 8'd0;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf = 0; m_mod = 8'd0; m_sw = 64'd0; m_sum = 8'd0;
        m_loading = 0; m_draining = 0; m_hold_left = HOLD;
    endtask

    task automatic model_edge();
        bit was_empty = (mq.size() == 0);
        bit start     = ioctl_download && ioctl_index == 8'd0;
        bit busy      = m_loading || m_draining || m_hold_left > 0;
        bit pop       = !was_empty && rom_ready;
        bit accept    = ioctl_wr && start && ioctl_addr[24:16] == 9'd0;
        if (start) begin
            if (!busy) m_sum = 8'd0;
            m_loading = 1; m_draining = 0; m_hold_left = 0;
        end else if (m_loading) begin
            if (!ioctl_download) begin m_loading = 0; m_draining = 1; end
        end else if (m_draining) begin
            if (was_empty) begin m_draining = 0; m_hold_left = HOLD; end
        end else if (m_hold_left > 0) begin
            m_hold_left--;
        end
        if (pop) begin
            m_sum = m_sum + mq[0][7:0];
            void'(mq.pop_front());
        end
        if (accept) begin
            if (mq.size() < DEPTH) mq.push_back({ioctl_addr[15:0], ioctl_dout});
            else m_ovf = 1;
        end
        if (ioctl_wr && ioctl_index == 8'd1) m_mod = ioctl_dout;
        if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr[24:3] == 22'd0)
            m_sw[ioctl_addr[2:0]*8 +: 8] = ioctl_dout;
    endtask

    task automatic compare();
        check("rom_wr", rom_wr, mq.size() != 0);
        if (mq.size() != 0) check("rom_head", {rom_addr, rom_data}, mq[0]);
        check("ioctl_wait", ioctl_wait, mq.size() >= DEPTH - 1);
        check("core_reset", core_reset, m_loading || m_draining || m_hold_left > 0);
        check("overflow", overflow, m_ovf);
        check("mod", mod, m_mod);
        check("sw", sw, m_sw);
        check("rom_sum", rom_sum, exp_sum());
    endtask

    task automatic step();
        if (!reset && rom_wr && rom_ready) popped.push_back({rom_addr, rom_data});
        if (ioctl_wait) wait_seen = 1;
        @(posedge clk_sys);
        if (!reset) model_edge();
        #1;
        compare();
    endtask

    task automatic put(input logic [7:0] ix, input logic [24:0] a, input logic [7:0] d);
        ioctl_wr = 1'b1; ioctl_index = ix; ioctl_addr = a; ioctl_dout = d;
        step();
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int n);
        n = 0;
        while (core_reset && n < 300) begin
            step();
            n++;
        end
        check(tag, core_reset, 1'b0);
    endtask

    function automatic logic [7:0] pick_index();
        case ($urandom_range(0, 3))
            0:       return 8'd0;
            1:       return 8'd1;
            2:       return 8'd254;
            default: return 8'd7;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, k;
        logic [23:0] want;

        // 1: reset release with no download
        model_reset();
        repeat (3) step();
        reset = 1'b0;
        wait_idle("t1_idle", n);
        check("t1_hold_cycles", n, HOLD);
        check("t1_rom_wr", rom_wr, 1'b0);
        check("t1_mod", mod, 8'd0);
        check("t1_sw", sw, 64'd0);

        // 2: eight bytes with rom_ready held high
        popped.delete(); wait_seen = 0; rom_ready = 1'b1; ioctl_download = 1'b1;
        for (int i = 0; i < 8; i++) begin
            put(8'd0, 25'(i), 8'(8'h10 + i));
            if (i == 0) check("t2_core_reset_on", core_reset, 1'b1);
        end
        ioctl_download = 1'b0;
        wait_idle("t2_idle", n);
        check("t2_pop_count", popped.size(), 8);
        for (int i = 0; i < 8 && i < popped.size(); i++) begin
            want = {16'(i), 8'(8'h10 + i)};
            check($sformatf("t2_pop%0d", i), popped[i], want);
        end
        check("t2_wait_never", wait_seen, 1'b0);
`ifdef IOCTL_LOAD_SEQUENCER_CHECKSUM_EN
        check("t2_rom_sum", rom_sum, 8'h9C);
`endif

        // 3: back-pressure honoured
        popped.delete(); rom_ready = 1'b0; ioctl_download = 1'b1; k = 0;
        for (int i = 0; i < 10; i++) begin
            if (ioctl_wait) break;
            put(8'd0, 25'(8'h20 + i), 8'(8'h30 + i));
            k++;
        end
        check("t3_writes_before_wait", k, DEPTH - 1);
        ioctl_download = 1'b0;
        repeat (3) step();
        rom_ready = 1'b1;
        wait_idle("t3_idle", n);
        check("t3_pop_count", popped.size(), DEPTH - 1);
        for (int i = 0; i < popped.size(); i++) begin
            want = {16'(8'h20 + i), 8'(8'h30 + i)};
            check($sformatf("t3_pop%0d", i), popped[i], want);
        end
        check("t3_overflow", overflow, 1'b0);

        // 4: back-pressure ignored, six bytes into a four-entry FIFO
        popped.delete(); rom_ready = 1'b0; ioctl_download = 1'b1;
        for (int i = 0; i < 6; i++) put(8'd0, 25'(12'h100 + i), 8'(8'h40 + i));
        ioctl_download = 1'b0;
        step();
        check("t4_overflow_set", overflow, 1'b1);
        rom_ready = 1'b1;
        wait_idle("t4_idle", n);
        check("t4_pop_count", popped.size(), DEPTH);
        for (int i = 0; i < popped.size(); i++) begin
            want = {16'(12'h100 + i), 8'(8'h40 + i)};
            check($sformatf("t4_pop%0d", i), popped[i], want);
        end
        check("t4_overflow_sticky", overflow, 1'b1);

        // 5: mod and DIP bytes
        k = 0; ioctl_download = 1'b1;
        put(8'd1, 25'd0, 8'h02);           k += core_reset;
        put(8'd254, 25'd0, 8'hAA);         k += core_reset;
        put(8'd254, 25'd2, 8'h55);         k += core_reset;
        put(8'd254, 25'd8, 8'h77);         k += core_reset;
        ioctl_download = 1'b0;
        step();                            k += core_reset;
        check("t5_mod", mod, 8'h02);
        check("t5_sw", sw, 64'h0000_0000_0055_00AA);
        check("t5_core_reset_quiet", k, 0);

        // 6: out-of-range address, then reset in the middle of a load
        rom_ready = 1'b0; ioctl_download = 1'b1;
        put(8'd0, 25'h10000, 8'h99);
        check("t6_high_addr_dropped", rom_wr, 1'b0);
        for (int i = 0; i < 3; i++) put(8'd0, 25'(i), 8'(8'h60 + i));
        check("t6_queued", rom_wr, 1'b1);
        reset = 1'b1;
        model_reset();
        #1;
        check("t6_rst_rom_wr", rom_wr, 1'b0);
        check("t6_rst_core_reset", core_reset, 1'b1);
        check("t6_rst_overflow", overflow, 1'b0);
        compare();
        step();
        reset = 1'b0; ioctl_download = 1'b0;
        wait_idle("t6_idle", n);
        check("t6_hold_cycles", n, HOLD);

        // Random traffic against the model
        rom_ready = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                model_reset();
                #1;
                compare();
                step();
                reset = 1'b0;
            end
            if ($urandom_range(0, 24) == 0) begin
                ioctl_download = !ioctl_download;
                if (ioctl_download) ioctl_index = pick_index();
            end
            ioctl_wr = 1'($urandom_range(0, 1));
            if (ioctl_wr && ioctl_wait && $urandom_range(0, 9) != 0) ioctl_wr = 1'b0;
            if ($urandom_range(0, 15) == 0) ioctl_addr = 25'h10000 + 25'($urandom_range(0, 255));
            else ioctl_addr = 25'($urandom_range(0, 15));
            ioctl_dout = 8'($urandom);
            rom_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        ioctl_wr = 1'b0; ioctl_download = 1'b0; rom_ready = 1'b1;
        wait_idle("rand_final_idle", n);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/ioctl_load_sequencer.md
Name: ioctl_load_sequencer

Overview:
- Sits between the hps_io ioctl download stream and the arcade core's ROM download port, all in clk_sys.
- Buffers ROM bytes (index 0) in a small FIFO and drains them to the core with a valid/ready handshake. Back-pressures the HPS through ioctl_wait.
- Latches the game-mod byte (index 1) and the DIP bytes (index 254).
- Sequences core_reset: held from the start of a ROM load until the FIFO has drained, plus a fixed hold time.

Parameters:
FIFO_DEPTH, 4, ROM byte FIFO entries; power of 2, minimum 2.
RST_HOLD, 64, clk_sys cycles core_reset stays high after drain completes; minimum 1.

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous active-high reset
ioctl_download  in  1  download active
ioctl_index  in  8  download target index
ioctl_wr  in  1  byte strobe, one cycle per byte
ioctl_addr  in  25  byte address
ioctl_dout  in  8  byte data
ioctl_wait  out  1  stall request to HPS
rom_addr  out  16  core ROM write address
rom_data  out  8  core ROM write data
rom_wr  out  1  valid, rom_addr/rom_data held while high
rom_ready  in  1  core accepts the byte when rom_wr & rom_ready
mod  out  8  game variant byte
sw  out  64  DIP bytes; byte n at [8n+7:8n]
core_reset  out  1  reset to core
overflow  out  1  sticky: a ROM byte was dropped because the FIFO was full
rom_sum  out  8  ROM checksum (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk_sys; reset asynchronous, active-high.
- Reset values:
  - state HOLD, hold counter = RST_HOLD, core_reset 1.
  - FIFO empty, so rom_wr 0 and ioctl_wait 0.
  - mod 0, sw all 0, overflow 0, rom_sum 0.
- rom_accept = ioctl_wr & ioctl_download & ioctl_index==0 & ioctl_addr[24:16]==0. Bytes with addr ≥ 0x10000 are silently discarded (no overflow).
- FIFO:
  - push on rom_accept; entry = {addr[15:0], dout}.
  - pop on rom_wr & rom_ready.
  - rom_wr = !empty; rom_addr/rom_data come from the head entry (registered or FWFT), stable while rom_wr & !rom_ready.
  - Push is taken when not full, or when full with a pop in the same cycle.
  - Push while full with no pop: byte dropped, overflow set; overflow clears only on reset.
  - Pointers wrap modulo FIFO_DEPTH; count is ceil(log2(FIFO_DEPTH))+1 bits.
- ioctl_wait = (count ≥ FIFO_DEPTH-1), combinational from the registered count. Asserts one entry before full so an in-flight strobe fits.
- mod: updated to ioctl_dout on ioctl_wr & ioctl_index==1 (any address; last write wins).
- sw: byte ioctl_addr[2:0] updated on ioctl_wr & ioctl_index==254 & ioctl_addr[24:3]==0. Other addresses are ignored.
- FSM:
  - IDLE: core_reset 0. ioctl_download & ioctl_index==0 → LOAD.
  - LOAD: core_reset 1. !ioctl_download → DRAIN.
  - DRAIN: core_reset 1. FIFO empty → HOLD, counter loaded with RST_HOLD.
  - HOLD: core_reset 1, counter decrements each cycle. Counter reaching 1 → IDLE, so core_reset is high for exactly RST_HOLD cycles of HOLD.
  - A new index-0 download in HOLD or DRAIN → LOAD; the FIFO keeps its contents.
  - Downloads of other indices do not leave IDLE and do not assert core_reset.
- Simultaneous events:
  - Index-0 rising edge on the same cycle as the first ioctl_wr: the byte is pushed and the FSM enters LOAD.
  - A mod or DIP write during LOAD is accepted normally.
- Reset mid-load: FIFO flushed, partially loaded bytes lost, FSM to HOLD.

Optional Feature:
- Macro: IOCTL_LOAD_SEQUENCER_CHECKSUM_EN.
- Defined: rom_sum is an 8-bit wrap-around sum of every byte popped to the core (rom_wr & rom_ready). It clears to 0 on entry to LOAD from IDLE, and is frozen otherwise.
- Undefined: rom_sum tied to 0 and no adder is built; all other behaviour is identical.

Test Plan:
1. Reset release with no download → core_reset high exactly 64 cycles after reset drops, then low; rom_wr 0; mod 0; sw 0.
2. Index 0, 8 bytes 0x10..0x17 at addr 0..7, rom_ready tied 1 → rom_wr pulses 8 times with matching addr/data in order, ioctl_wait never high, core_reset high from download start until 64 cycles after the last pop; checksum build gives rom_sum 0x9C.
3. Index 0, rom_ready held 0, ioctl_wr every cycle → ioctl_wait rises when count reaches 3 (FIFO_DEPTH 4). Bench stops strobing; releasing rom_ready drains all bytes in order; overflow stays 0.
4. Same as 3, but the bench ignores ioctl_wait and writes 6 bytes → first 4 delivered, last 2 dropped, overflow 1 and stays 1 until reset.
5. Index 1 write 0x02, then index 254 writes 0xAA at addr 0 and 0x55 at addr 2, then index-254 write at addr 8 → mod 0x02; sw[7:0] 0xAA, sw[23:16] 0x55, all other sw bytes 0; core_reset stays 0 throughout.
6. Index 0 write at addr 0x10000 → no push, no rom_wr; reset asserted mid-LOAD with 3 bytes queued → rom_wr 0 immediately, core_reset 1, hold sequence restarts.
